// File: rtl/proc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_ctrl_pkg
//  Description : Shared encodings for the processor controller and the ALU:
//                FSM states, opcodes and instruction field positions.
//  Revision    : 1.0  initial release
// ============================================================================
package proc_ctrl_pkg;

    localparam int c_INSTR_W  = 9;
    localparam int c_TYPE_BIT = 8;
    localparam int c_ROP_MSB  = 7;
    localparam int c_ROP_LSB  = 4;
    localparam int c_REG_MSB  = 3;
    localparam int c_REG_LSB  = 0;
    localparam int c_IOP_MSB  = 7;
    localparam int c_IOP_LSB  = 5;
    localparam int c_IMM_MSB  = 4;
    localparam int c_IMM_LSB  = 0;

    typedef logic [2:0] state_t;
    typedef logic [3:0] rop_t;
    typedef logic [2:0] iop_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_FETCH  = 3'd1;
    localparam state_t c_ST_DECODE = 3'd2;
    localparam state_t c_ST_EXEC   = 3'd3;
    localparam state_t c_ST_MEM    = 3'd4;
    localparam state_t c_ST_WB     = 3'd5;
    localparam state_t c_ST_HALT   = 3'd6;

    localparam rop_t c_ROP_ADD = 4'b0000;
    localparam rop_t c_ROP_SUB = 4'b0001;
    localparam rop_t c_ROP_AND = 4'b0010;
    localparam rop_t c_ROP_OR  = 4'b0011;
    localparam rop_t c_ROP_XOR = 4'b0100;
    localparam rop_t c_ROP_NOT = 4'b0101;
    localparam rop_t c_ROP_SLR = 4'b0110;
    localparam rop_t c_ROP_SRR = 4'b0111;
    localparam rop_t c_ROP_LW  = 4'b1000;
    localparam rop_t c_ROP_SW  = 4'b1001;
    localparam rop_t c_ROP_MOV = 4'b1010;
    localparam rop_t c_ROP_CMP = 4'b1011;
    localparam rop_t c_ROP_BR  = 4'b1100;
    localparam rop_t c_ROP_J   = 4'b1101;
    localparam rop_t c_ROP_SET = 4'b1110;
    localparam rop_t c_ROP_NOP = 4'b1111;

    localparam iop_t c_IOP_ADDI = 3'b000;
    localparam iop_t c_IOP_SUBI = 3'b001;
    localparam iop_t c_IOP_SLL  = 3'b010;
    localparam iop_t c_IOP_SRL  = 3'b011;
    localparam iop_t c_IOP_ANDI = 3'b100;
    localparam iop_t c_IOP_ORI  = 3'b101;
    localparam iop_t c_IOP_RSV  = 3'b110;
    localparam iop_t c_IOP_HALT = 3'b111;

    // Arithmetic and shift operations are the only ones that produce a carry.
    function automatic logic scUpdates(input logic typeCode, input rop_t rOp, input iop_t iOp);
        if (typeCode)
            return (iOp == c_IOP_ADDI) || (iOp == c_IOP_SUBI) ||
                   (iOp == c_IOP_SLL)  || (iOp == c_IOP_SRL);
        else
            return (rOp == c_ROP_ADD) || (rOp == c_ROP_SUB) ||
                   (rOp == c_ROP_SLR) || (rOp == c_ROP_SRR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : proc_ctrl_if
//  Description : Controller <-> datapath/memory signal bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface proc_ctrl_if;
    import proc_ctrl_pkg::*;

    logic                 start;
    logic [c_INSTR_W-1:0] instr;
    logic                 alu_branch;
    logic                 alu_sc_out;
    logic                 mem_ack;

    logic                 type_code;
    rop_t                 r_op;
    iop_t                 i_op;
    logic [4:0]           imm;
    logic [3:0]           reg_addr;
    logic                 sc_in;
    logic                 ir_load;
    logic                 pc_inc;
    logic                 pc_jump;
    logic                 acc_we;
    logic                 reg_we;
    logic                 mem_re;
    logic                 mem_we;
    logic                 done;
    state_t               state;

    // master: the controller; slave: the datapath / memory side.
    modport master (
        input  start, instr, alu_branch, alu_sc_out, mem_ack,
        output type_code, r_op, i_op, imm, reg_addr, sc_in,
               ir_load, pc_inc, pc_jump, acc_we, reg_we,
               mem_re, mem_we, done, state
    );

    modport slave (
        output start, instr, alu_branch, alu_sc_out, mem_ack,
        input  type_code, r_op, i_op, imm, reg_addr, sc_in,
               ir_load, pc_inc, pc_jump, acc_we, reg_we,
               mem_re, mem_we, done, state
    );

endinterface
`default_nettype wire

// File: rtl/proc_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : proc_ctrl_decode
//  Description : Combinational split of the instruction register into fields
//                and instruction-class flags.
//  Revision    : 1.0  initial release
// ============================================================================
module proc_ctrl_decode
    import proc_ctrl_pkg::*;
(
    input  logic [c_INSTR_W-1:0] i_ir,
    output logic                 o_typeCode,
    output rop_t                 o_rOp,
    output iop_t                 o_iOp,
    output logic [4:0]           o_imm,
    output logic [3:0]           o_regAddr,
    output logic                 o_isMem,
    output logic                 o_isLoad,
    output logic                 o_isStore,
    output logic                 o_isBranch,
    output logic                 o_isJump,
    output logic                 o_isHalt,
    output logic                 o_isReserved,
    output logic                 o_scUpdate,
    output logic                 o_regWrite
);

    logic w_isR;

    assign o_typeCode = i_ir[c_TYPE_BIT];
    assign o_rOp      = i_ir[c_ROP_MSB:c_ROP_LSB];
    assign o_iOp      = i_ir[c_IOP_MSB:c_IOP_LSB];
    assign o_imm      = i_ir[c_IMM_MSB:c_IMM_LSB];
    assign o_regAddr  = i_ir[c_REG_MSB:c_REG_LSB];

    assign w_isR = ~o_typeCode;

    assign o_isLoad     = w_isR && (o_rOp == c_ROP_LW);
    assign o_isStore    = w_isR && (o_rOp == c_ROP_SW);
    assign o_isMem      = o_isLoad || o_isStore;
    assign o_isBranch   = w_isR && (o_rOp == c_ROP_BR);
    assign o_isJump     = w_isR && (o_rOp == c_ROP_J);
    assign o_isHalt     = o_typeCode && (o_iOp == c_IOP_HALT);
    assign o_isReserved = o_typeCode && (o_iOp == c_IOP_RSV);
    assign o_scUpdate   = scUpdates(o_typeCode, o_rOp, o_iOp);
    // Loads land in the register file just like SET.
    assign o_regWrite   = o_isLoad || (w_isR && (o_rOp == c_ROP_SET));

endmodule
`default_nettype wire

// File: rtl/proc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : proc_ctrl
//  Description : Multi-cycle processor control FSM (fetch, decode, execute,
//                memory, write-back) with registered control outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module proc_ctrl
    import proc_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    proc_ctrl_if.master     ctrlBus
);

    state_t               r_state;
    logic [c_INSTR_W-1:0] r_ir;
    logic                 r_typeCode;
    rop_t                 r_rOp;
    iop_t                 r_iOp;
    logic [4:0]           r_imm;
    logic [3:0]           r_regAddr;
    logic                 r_scIn;
    logic                 r_irLoad;
    logic                 r_pcInc;
    logic                 r_pcJump;
    logic                 r_accWe;
    logic                 r_regWe;
    logic                 r_memRe;
    logic                 r_memWe;
    logic                 r_done;

    logic                 w_typeCode;
    rop_t                 w_rOp;
    iop_t                 w_iOp;
    logic [4:0]           w_imm;
    logic [3:0]           w_regAddr;
    logic                 w_isMem;
    logic                 w_isLoad;
    logic                 w_isStore;
    logic                 w_isBranch;
    logic                 w_isJump;
    logic                 w_isHalt;
    logic                 w_isReserved;
    logic                 w_scUpdate;
    logic                 w_regWrite;
    logic                 w_brResolve;
    logic                 w_swAck;

    proc_ctrl_decode u_decode (
        .i_ir         (r_ir),
        .o_typeCode   (w_typeCode),
        .o_rOp        (w_rOp),
        .o_iOp        (w_iOp),
        .o_imm        (w_imm),
        .o_regAddr    (w_regAddr),
        .o_isMem      (w_isMem),
        .o_isLoad     (w_isLoad),
        .o_isStore    (w_isStore),
        .o_isBranch   (w_isBranch),
        .o_isJump     (w_isJump),
        .o_isHalt     (w_isHalt),
        .o_isReserved (w_isReserved),
        .o_scUpdate   (w_scUpdate),
        .o_regWrite   (w_regWrite)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_ir       <= '0;
            r_typeCode <= 1'b0;
            r_rOp      <= '0;
            r_iOp      <= '0;
            r_imm      <= '0;
            r_regAddr  <= '0;
            r_scIn     <= 1'b0;
            r_irLoad   <= 1'b0;
            r_pcInc    <= 1'b0;
            r_pcJump   <= 1'b0;
            r_accWe    <= 1'b0;
            r_regWe    <= 1'b0;
            r_memRe    <= 1'b0;
            r_memWe    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Strobes are set on the edge entering the state that owns them.
            r_irLoad <= 1'b0;
            r_pcInc  <= 1'b0;
            r_pcJump <= 1'b0;
            r_accWe  <= 1'b0;
            r_regWe  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (ctrlBus.start) begin
                        r_state  <= c_ST_FETCH;
                        r_irLoad <= 1'b1;
                    end
                end
                c_ST_FETCH: begin
                    r_ir    <= ctrlBus.instr;
                    r_state <= c_ST_DECODE;
                end
                c_ST_DECODE: begin
                    r_typeCode <= w_typeCode;
                    r_rOp      <= w_rOp;
                    r_iOp      <= w_iOp;
                    r_imm      <= w_imm;
                    r_regAddr  <= w_regAddr;
                    if (w_isHalt) begin
                        r_state <= c_ST_HALT;
                        r_done  <= 1'b1;
                    end else begin
                        r_state  <= c_ST_EXEC;
                        r_pcJump <= w_isJump;
                        r_pcInc  <= w_isReserved;
                    end
                end
                c_ST_EXEC: begin
                    if (w_isMem) begin
                        r_state <= c_ST_MEM;
                        r_memRe <= w_isLoad;
                        r_memWe <= w_isStore;
                    end else if (w_isBranch || w_isJump || w_isReserved) begin
                        r_state  <= c_ST_FETCH;
                        r_irLoad <= 1'b1;
                    end else begin
                        r_state <= c_ST_WB;
                        r_regWe <= w_regWrite;
                        r_accWe <= ~w_regWrite;
                        r_pcInc <= 1'b1;
                    end
                end
                c_ST_MEM: begin
                    if (ctrlBus.mem_ack) begin
                        r_memRe <= 1'b0;
                        r_memWe <= 1'b0;
                        if (w_isLoad) begin
                            r_state <= c_ST_WB;
                            r_regWe <= 1'b1;
                            r_pcInc <= 1'b1;
                        end else begin
                            r_state  <= c_ST_FETCH;
                            r_irLoad <= 1'b1;
                        end
                    end
                end
                c_ST_WB: begin
                    if (w_scUpdate)
                        r_scIn <= ctrlBus.alu_sc_out;
                    r_state  <= c_ST_FETCH;
                    r_irLoad <= 1'b1;
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Branch outcome and store completion are only known within their own
    // cycle, so those PC strobes follow the input instead of a register.
    assign w_brResolve = (r_state == c_ST_EXEC) && w_isBranch && !reset;
    assign w_swAck     = (r_state == c_ST_MEM) && w_isStore && ctrlBus.mem_ack && !reset;

    assign ctrlBus.pc_jump   = r_pcJump || (w_brResolve && ctrlBus.alu_branch);
    assign ctrlBus.pc_inc    = r_pcInc || (w_brResolve && !ctrlBus.alu_branch) || w_swAck;
    assign ctrlBus.type_code = r_typeCode;
    assign ctrlBus.r_op      = r_rOp;
    assign ctrlBus.i_op      = r_iOp;
    assign ctrlBus.imm       = r_imm;
    assign ctrlBus.reg_addr  = r_regAddr;
    assign ctrlBus.sc_in     = r_scIn;
    assign ctrlBus.ir_load   = r_irLoad;
    assign ctrlBus.acc_we    = r_accWe;
    assign ctrlBus.reg_we    = r_regWe;
    assign ctrlBus.mem_re    = r_memRe;
    assign ctrlBus.mem_we    = r_memWe;
    assign ctrlBus.done      = r_done;
    assign ctrlBus.state     = r_state;

endmodule
`default_nettype wire
